fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the in-order RISC-V core. It sits directly upstream of hazard resolution: it consumes `pc_pause`, the IF/ID bits of `pipe_pause`/`pipe_bubble`, and the execute-stage redirect. It issues in-order requests to instruction memory through a 2-entry fetch buffer and delivers `{valid, pc, instr}` to decode. Stale responses left over from a redirect are discarded.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/fetch_buf.sv | 121 ++++++++++++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared constants and types for the in-order RISC-V core front end.
//   XLEN             : architectural address/data width (only 32 is supported)
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0) shown when IF/ID is empty
//   RESET_PC_DEFAULT : default first fetch address after reset
//   FB_DEPTH         : fetch buffer entries (one per outstanding request)
//   fb_entry_t       : one fetch buffer slot {pc, instr, filled}
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int FB_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            filled;
  } fb_entry_t;

  // Sequential fetch address; wraps naturally modulo 2^XLEN.
  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf
// Two-entry in-order fetch queue. Each accepted imem request allocates the
// tail slot with its PC; the matching response fills the oldest unfilled
// slot; decode pops the head once it is filled. flush drops everything.
//   clk, rst_n      : clock, synchronous active-low reset
//   flush           : discard all entries (redirect)
//   alloc_en/pc     : allocate tail slot for a request accepted this cycle
//   fill_en/instr   : write a response into the oldest unfilled slot
//   pop_en          : remove the head slot (only when head_filled)
//   count           : live entries, 0..2
//   head_filled     : head slot holds a returned instruction
//   head_pc/instr   : head slot contents
//   unfilled        : live entries still waiting for their response
module fetch_buf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc_en,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_en,
  input  logic [31:0]     fill_instr,
  input  logic            pop_en,
  output logic [1:0]      count,
  output logic            head_filled,
  output logic [XLEN-1:0] head_pc,
  output logic [31:0]     head_instr,
  output logic [1:0]      unfilled
);

  logic       head_reg, head_next;
  logic [1:0] count_reg, count_next;

  fb_entry_t [FB_DEPTH-1:0] entry_q;
  logic [FB_DEPTH-1:0]      live;
  logic [FB_DEPTH-1:0]      pending;

  logic tail_idx;
  logic fill_idx;
  logic fill_hit;

  // With two slots the tail is head+count mod 2. When full and popping in
  // the same cycle this lands on the head slot, which is exactly the slot
  // being freed, so allocate-on-pop needs no special case.
  always_comb begin
    tail_idx = head_reg ^ count_reg[0];
  end

  // Responses are in order, so the oldest unfilled live slot owns the next one.
  always_comb begin
    fill_idx = head_reg;
    fill_hit = 1'b0;
    if (pending[head_reg]) begin
      fill_idx = head_reg;
      fill_hit = 1'b1;
    end else if (pending[~head_reg]) begin
      fill_idx = ~head_reg;
      fill_hit = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FB_DEPTH; gi++) begin : g_entry
      localparam logic IDX = 1'(gi);
      fb_entry_t entry_reg;
      logic      offset;

      // Position of this slot relative to the head; live if inside count.
      assign offset       = IDX ^ head_reg;
      assign live[gi]     = ({1'b0, offset} < count_reg);
      assign pending[gi]  = live[gi] && !entry_reg.filled;
      assign entry_q[gi]  = entry_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          entry_reg <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
        end else if (!flush) begin
          if (alloc_en && (tail_idx == IDX)) begin
            entry_reg <= '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
          end else if (fill_en && fill_hit && (fill_idx == IDX)) begin
            entry_reg.instr  <= fill_instr;
            entry_reg.filled <= 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    head_next  = head_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = 1'b0;
      count_next = 2'd0;
    end else begin
      if (pop_en) begin
        head_next = ~head_reg;
      end
      count_next = count_reg + {1'b0, alloc_en} - {1'b0, pop_en};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      head_reg  <= head_next;
      count_reg <= count_next;
    end
  end

  assign count       = count_reg;
  assign head_filled = live[head_reg] && entry_q[head_reg].filled;
  assign head_pc     = entry_q[head_reg].pc;
  assign head_instr  = entry_q[head_reg].instr;
  assign unfilled    = {1'b0, pending[0]} + {1'b0, pending[1]};

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch and IF/ID pipeline register. Issues in-order requests to
// instruction memory, tracks them in fetch_buf, discards responses that
// belong to requests made before a redirect, and feeds decode.
//   clk, rst_n        : clock, synchronous active-low reset
//   pc_pause          : load-use stall, blocks new request issue only
//   ifid_pause        : hold IF/ID contents
//   ifid_bubble       : clear IF/ID valid
//   redirect_valid/pc : taken branch/jump from EX; overrides pause and bubble
//   imem_req_*        : request channel, imem_addr is always the pc register
//   imem_rsp_*        : in-order response strobe, cannot be back-pressured
//   id_valid/pc/instr : IF/ID register presented to decode
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_pause,
  input  logic            ifid_pause,
  input  logic            ifid_bubble,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr
);

  logic [XLEN-1:0] pc_reg, pc_next;
  // One bit of headroom over the nominal 0..2 range: a memory that keeps
  // accepting across back-to-back redirects can leave more stale responses.
  logic [2:0]      kill_cnt_reg, kill_cnt_next;
  logic            id_valid_reg, id_valid_next;
  logic [XLEN-1:0] id_pc_reg, id_pc_next;
  logic [31:0]     id_instr_reg, id_instr_next;

  logic [1:0]      fb_count;
  logic            fb_head_filled;
  logic [XLEN-1:0] fb_head_pc;
  logic [31:0]     fb_head_instr;
  logic [1:0]      fb_unfilled;

  logic       pop;
  logic       req_fire;
  logic       fill_en;
  logic [2:0] kill_sum;

  // Head moves into IF/ID only when nothing above it in priority applies.
  assign pop = rst_n && !redirect_valid && !ifid_bubble && !ifid_pause && fb_head_filled;

  // A slot freed by this cycle's pop may be reused by this cycle's request.
  assign imem_req_valid = rst_n && !redirect_valid && !pc_pause &&
                          ((fb_count < 2'd2) || pop);
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign imem_addr = pc_reg;

  // During a redirect the buffer is flushed, so the response is only counted.
  assign fill_en  = imem_rsp_valid && (kill_cnt_reg == 3'd0) && !redirect_valid;
  assign kill_sum = kill_cnt_reg + {1'b0, fb_unfilled};

  fetch_buf u_fetch_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect_valid),
    .alloc_en    (req_fire),
    .alloc_pc    (pc_reg),
    .fill_en     (fill_en),
    .fill_instr  (imem_rsp_data),
    .pop_en      (pop),
    .count       (fb_count),
    .head_filled (fb_head_filled),
    .head_pc     (fb_head_pc),
    .head_instr  (fb_head_instr),
    .unfilled    (fb_unfilled)
  );

  always_comb begin
    pc_next       = pc_reg;
    kill_cnt_next = kill_cnt_reg;

    if (redirect_valid) begin
      pc_next = redirect_pc;
      // Every unfilled request becomes stale; a response landing right now
      // settles one of them (already-stale or just-flushed) immediately.
      if (imem_rsp_valid && (kill_sum != 3'd0)) begin
        kill_cnt_next = kill_sum - 3'd1;
      end else begin
        kill_cnt_next = kill_sum;
      end
    end else begin
      if (req_fire) begin
        pc_next = seq_pc(pc_reg);
      end
      if (imem_rsp_valid && (kill_cnt_reg != 3'd0)) begin
        kill_cnt_next = kill_cnt_reg - 3'd1;
      end
    end
  end

  always_comb begin
    id_valid_next = id_valid_reg;
    id_pc_next    = id_pc_reg;
    id_instr_next = id_instr_reg;
    if (redirect_valid || ifid_bubble) begin
      id_valid_next = 1'b0;
    end else if (ifid_pause) begin
      id_valid_next = id_valid_reg;
    end else if (fb_head_filled) begin
      id_valid_next = 1'b1;
      id_pc_next    = fb_head_pc;
      id_instr_next = fb_head_instr;
    end else begin
      id_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      kill_cnt_reg <= 3'd0;
      id_valid_reg <= 1'b0;
      id_pc_reg    <= '0;
      id_instr_reg <= NOP_INSTR;
    end else begin
      pc_reg       <= pc_next;
      kill_cnt_reg <= kill_cnt_next;
      id_valid_reg <= id_valid_next;
      id_pc_reg    <= id_pc_next;
      id_instr_reg <= id_instr_next;
    end
  end

  assign id_valid = id_valid_reg;
  assign id_pc    = id_pc_reg;
  assign id_instr = id_instr_reg;

  // A response must belong either to a stale request or to a waiting slot.
  rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> ((kill_cnt_reg != 3'd0) || (fb_unfilled != 2'd0)));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed scenarios with hand-computed PC sequences. Stimulus pushes the
// expected decode PCs into a scoreboard; a monitor pops and compares every
// newly loaded IF/ID instruction. The memory model returns instr = addr.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_pause, ifid_pause, ifid_bubble;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_pc, id_instr;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_pause       (pc_pause),
    .ifid_pause     (ifid_pause),
    .ifid_bubble    (ifid_bubble),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int mem_lat = 1;
  int ecnt = 0;

  logic        pause_last = 1'b0;
  logic        valid_last = 1'b0;
  logic [31:0] pc_last = '0;
  logic [31:0] instr_last = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] first, input int n);
    logic [31:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  task automatic wait_id(input logic [31:0] x);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (id_valid && id_pc == x) break;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_id: got no id_pc %h in 200 cycles, expected it", x);
    end
    tick();
  endtask

  // Memory: accepts on valid&&ready, answers mem_lat cycles later, in order.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) mq.delete();
      else if (imem_req_valid && imem_req_ready)
        mq.push_back('{addr: imem_addr, due: ecnt + mem_lat});
      @(posedge clk);
      ecnt++;
      #1;
      if (mq.size() > 0 && mq[0].due <= ecnt) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq[0].addr;
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: every freshly loaded IF/ID instruction pops the scoreboard;
  // cycles following a sampled ifid_pause must hold the previous contents.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && id_valid) begin
        if (pause_last && valid_last) begin
          check32("hold_pc", id_pc, pc_last);
          check32("hold_instr", id_instr, instr_last);
        end else if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_id: got id_pc %h expected no instruction", id_pc);
        end else begin
          exp = sb_q.pop_front();
          check32("id_pc", id_pc, exp);
          check32("id_instr", id_instr, exp);
          $display("txn id_pc=%h id_instr=%h exp=%h", id_pc, id_instr, exp);
        end
      end
      pause_last = rst_n && ifid_pause;
      valid_last = rst_n && id_valid;
      pc_last    = id_pc;
      instr_last = id_instr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    rst_n          = 1'b0;
    pc_pause       = 1'b0;
    ifid_pause     = 1'b0;
    ifid_bubble    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check32("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check32("rst_id_pc", id_pc, 32'h0);
    check32("rst_id_instr", id_instr, 32'h0000_0013);
    check32("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();

    // Free run, 1-cycle memory: 0x00..0x44 delivered before the final pc_pause
    push_seq(32'h0, 18);
    rst_n = 1'b1;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) check32("first_req_addr", imem_addr, 32'h0);
      if (id_valid) begin
        first = k;
        break;
      end
      tick();
    end
    check32("first_valid_cycle", 32'(first), 32'd3);

    // ifid_pause for 3 edges while id_pc = 0x10
    wait_id(32'h0C);
    ifid_pause = 1'b1;
    repeat (3) tick();
    ifid_pause = 1'b0;

    // pc_pause for 2 cycles while id_pc = 0x28
    wait_id(32'h24);
    pc_pause = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check32("pc_pause_noreq", {31'd0, imem_req_valid}, 32'd0);
      tick();
    end
    pc_pause = 1'b0;

    // Quiesce: request for 0x48 is blocked, 0x44 is the last delivered
    wait_id(32'h38);
    pc_pause = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check32("quiesce_noreq", {31'd0, imem_req_valid}, 32'd0);
    check32("quiesce_addr", imem_addr, 32'h48);
    check32("sb_empty_run", 32'(sb_q.size()), 32'd0);
    tick();

    // Redirect with 0x48, 0x4C in flight, 3-cycle memory
    push_seq(32'h100, 2);
    mem_lat  = 3;
    pc_pause = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check32("redir_noreq", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check32("redir_target_addr", imem_addr, 32'h100);
    check32("redir_id_invalid", {31'd0, id_valid}, 32'd0);
    tick();
    tick();
    pc_pause = 1'b1;
    repeat (10) tick();
    check32("sb_empty_redir", 32'(sb_q.size()), 32'd0);

    // Redirect coinciding with a response and one more outstanding request
    push_seq(32'h200, 2);
    mem_lat  = 2;
    pc_pause = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    pc_pause = 1'b1;
    tick();
    ifid_bubble = 1'b1;
    tick();
    ifid_bubble = 1'b0;
    @(negedge clk);
    check32("bubble_clears", {31'd0, id_valid}, 32'd0);
    repeat (8) tick();
    check32("sb_empty_rsp_redir", 32'(sb_q.size()), 32'd0);

    // Ready low 5 cycles, then fetch across the 2^32 wrap
    push_seq(32'hFFFF_FFF8, 3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    mem_lat        = 1;
    imem_req_ready = 1'b0;
    pc_pause       = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check32("stall_valid", {31'd0, imem_req_valid}, 32'd1);
      check32("stall_addr", imem_addr, 32'hFFFF_FFF8);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    @(negedge clk);
    check32("addr_fc", imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check32("wrap_addr", imem_addr, 32'h0000_0000);
    tick();
    pc_pause = 1'b1;
    repeat (8) tick();
    check32("sb_empty_wrap", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
